// File: rtl/sd_sector_buffer.sv
// Single-sector buffer between a 32-bit host port and the byte-wide sd_controller stream.
// Optional command watchdog is enabled with the SD_SECBUF_TIMEOUT_EN macro.
module sd_sector_buffer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_lba,
  output logic        o_cmd_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  input  logic [6:0]  i_host_adr,
  input  logic        i_host_we,
  input  logic [31:0] i_host_wdata,
  output logic [31:0] o_host_rdata,
  input  logic        i_sd_ready,
  output logic        o_sd_ren,
  output logic        o_sd_wen,
  output logic [31:0] o_sd_blk_num,
  output logic [31:0] o_sd_adr,
  input  logic [7:0]  i_sd_data,
  input  logic        i_sd_data_en,
  output logic [7:0]  o_sd_wdata,
  input  logic        i_sd_data_ready
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitAck, StXfer, StFin} state_e;

  state_e      state;
  logic        wr_mode;
  logic [9:0]  ptr;
  logic        ovf;
  // Byte lanes: lane b holds byte 4k+b of word k
  logic [7:0]  ram [4][128];

  logic        accept;
  logic        rd_strobe;
  logic        wr_strobe;
  logic [8:0]  src_idx;

  assign o_cmd_ready  = (state == StIdle) & i_sd_ready;
  assign o_sd_blk_num = 32'd1;
  assign accept       = i_cmd_valid & o_cmd_ready;
  assign rd_strobe    = (state == StXfer) & ~wr_mode & i_sd_data_en;
  assign wr_strobe    = (state == StXfer) & wr_mode & i_sd_data_ready;
  // Park on byte 0 while idle so the first write byte is ready before the request
  assign src_idx      = (state == StIdle) ? 9'd0 : ptr[8:0];

  always_ff @(posedge i_clk) begin
    if (i_host_we && !o_busy) begin
      for (int b = 0; b < 4; b++) begin
        ram[b][i_host_adr] <= i_host_wdata[8*b +: 8];
      end
    end
    if (rd_strobe && !ptr[9]) begin
      ram[ptr[1:0]][ptr[8:2]] <= i_sd_data;
    end
  end

`ifdef SD_SECBUF_TIMEOUT_EN
  localparam logic [26:0] WdogLimit = 27'(TIMEOUT_CYCLES - 1);
  logic [26:0] wdog;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= StIdle;
      wr_mode      <= 1'b0;
      ptr          <= 10'd0;
      ovf          <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_sd_ren     <= 1'b0;
      o_sd_wen     <= 1'b0;
      o_sd_adr     <= 32'd0;
      o_sd_wdata   <= 8'd0;
      o_host_rdata <= 32'd0;
`ifdef SD_SECBUF_TIMEOUT_EN
      wdog         <= 27'd0;
`endif
    end else begin
      o_done       <= 1'b0;
      o_sd_ren     <= 1'b0;
      o_sd_wen     <= 1'b0;
      o_host_rdata <= {ram[3][i_host_adr], ram[2][i_host_adr],
                       ram[1][i_host_adr], ram[0][i_host_adr]};
      o_sd_wdata   <= ram[src_idx[1:0]][src_idx[8:2]];

      // Saturate at 512; any further strobe is remembered as an error
      if (rd_strobe || wr_strobe) begin
        if (ptr[9]) ovf <= 1'b1;
        else        ptr <= ptr + 10'd1;
      end

      case (state)
        StIdle: begin
          if (accept) begin
            wr_mode  <= i_cmd_write;
            o_sd_adr <= i_cmd_lba;
            ptr      <= 10'd0;
            ovf      <= 1'b0;
            o_err    <= 1'b0;
            o_busy   <= 1'b1;
            o_sd_ren <= ~i_cmd_write;
            o_sd_wen <= i_cmd_write;
            state    <= StIssue;
          end
        end
        StIssue:   state <= StWaitAck;
        StWaitAck: if (!i_sd_ready) state <= StXfer;
        StXfer:    if (i_sd_ready) state <= StFin;
        StFin: begin
          if (ptr != 10'd512 || ovf) o_err <= 1'b1;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= StIdle;
        end
        default:   state <= StIdle;
      endcase

`ifdef SD_SECBUF_TIMEOUT_EN
      if (accept)      wdog <= 27'd0;
      else if (o_busy) wdog <= wdog + 27'd1;
      if ((state == StWaitAck || state == StXfer) && wdog >= WdogLimit) begin
        o_err  <= 1'b1;
        o_done <= 1'b1;
        o_busy <= 1'b0;
        state  <= StIdle;
      end
`endif
    end
  end

endmodule
